coin_start_seq: RTL
===================

Name: coin_start_seq

Overview:
- Sequences the cabinet coin/start inputs of the arcade core from the player's "Start 1P" / "Start 2P" buttons (keyboard or joystick).
- Replaces the crude coin = start1 | start2 OR with a timed sequence: coin pulse(s), a gap, then a start pulse. Timing is measured in video frames.
- Sits in the emu top level between the input decode and the core's in0/in1 coin/start bits. Outputs are active-high; the top level inverts them.

Parameters:
- COIN_FRAMES, 4: frame ticks each coin pulse is held asserted.
- GAP_FRAMES, 8: frame ticks between pulses (coin-to-coin and coin-to-start).
- START_FRAMES, 4: frame ticks the start pulse is held asserted.
- P2_COINS, 2: coins inserted before a 2-player start; 1-player always inserts 1 coin.
- All parameters range 1..255. A value of 0 is treated as 1.

Ports:
- CLK in 1: system clock (clk_sys).
- RESET_N in 1: asynchronous, active-low reset.
- I_VBLANK in 1: core vblank level; its rising edge is the frame tick.
- I_START1 in 1: level, player requests a 1-player start.
- I_START2 in 1: level, player requests a 2-player start.
- O_COIN out 1: coin switch, active-high.
- O_START1 out 1: start-1 switch, active-high.
- O_START2 out 1: start-2 switch, active-high.
- O_BUSY out 1: high whenever the FSM is not in IDLE.

Behaviour:
- Reset: RESET_N low asynchronously clears the FSM to IDLE, all counters and edge registers to 0, and all outputs to 0. This applies mid-sequence: the sequence is abandoned and no completing pulses are issued.
- Frame tick: tick = I_VBLANK & ~vblank_q, where vblank_q is registered each CLK. Tick is one CLK wide.
- Request detect:
  - Rising edges of I_START1 and I_START2 are detected from registered copies.
  - Edges are acted on only in IDLE; edges arriving while not in IDLE are dropped (no queue).
  - Simultaneous edges in IDLE: start2 wins.
- Latched at request: sel (0 = P1, 1 = P2) and coins_left = sel ? P2_COINS : 1.
- frame_cnt (8 bits) is cleared on every state entry and increments on each tick. A state with length N exits on the tick where frame_cnt == N-1, so it lasts exactly N ticks after entry.
- States:
  - IDLE: outputs 0. On a request, latch sel and coins_left, then go to COIN.
  - COIN: O_COIN = 1. After COIN_FRAMES ticks, decrement coins_left, then go to GAP.
  - GAP: outputs 0. After GAP_FRAMES ticks: if coins_left != 0 go to COIN, else go to START.
  - START: O_START1 = ~sel and O_START2 = sel. After START_FRAMES ticks, go to RELEASE.
  - RELEASE: outputs 0. Wait until the selected button input is low, then for one further tick, then go to IDLE. This prevents auto-repeat from a held button.
- Outputs are registered, decoded from the next state, so each output changes in the same cycle as the state register.
- Only one of O_COIN, O_START1, O_START2 is high at any time.
- O_BUSY = (state != IDLE).
- If no ticks arrive (vblank stuck), the FSM holds in its current state indefinitely. This is legal and requires no timeout.

Decomposition:
- Package coin_start_pkg holds:
  - the state enum (IDLE, COIN, GAP, START, RELEASE), 3 bits;
  - the localparam clamp function max1(x) used for the 0-to-1 parameter clamp.
- One natural sub-module, frame_tick: the vblank edge detector plus the 8-bit frame counter, with a clear input and a "count reached N-1 on tick" output.
- The FSM lives in coin_start_seq.

Test Plan:
- Default params, I_VBLANK period 100 CLK, pulse I_START1 for 1 frame → O_COIN high for exactly 4 ticks, 8-tick gap, O_START1 high 4 ticks, O_START2 never high, O_BUSY returns low one tick after release.
- Pulse I_START2 → two 4-tick O_COIN pulses separated by 8 ticks, 8-tick gap, O_START2 for 4 ticks. O_START1 stays 0 throughout.
- I_START1 and I_START2 rise in the same CLK → P2 sequence (two coins, O_START2).
- Hold I_START1 high for 50 frames → exactly one sequence. A second sequence starts only after release plus one tick and a new rising edge. An edge injected during GAP is ignored.
- Drop RESET_N during the second COIN pulse of a P2 sequence → all outputs 0 in the same cycle, asynchronously. After release, IDLE with O_BUSY = 0 and no start pulse.
- COIN_FRAMES=0, GAP_FRAMES=1 → coin pulse lasts 1 tick and the gap lasts 1 tick.

Source files
------------

// File: rtl/coin_start_seq_pkg.sv
// coin_start_pkg: shared state encoding and parameter clamp for the coin/start sequencer
package coin_start_pkg;
  typedef enum logic [2:0] {IDLE, COIN, GAP, START, RELEASE} state_t;
  function automatic logic [7:0] max1(input int x);
    return (x < 1) ? 8'd1 : 8'(x);
  endfunction
endpackage

// File: rtl/coin_start_seq_frame_tick.sv
// frame_tick: vblank rising-edge frame tick plus frame counter with "reached len-1 on tick" flag
module frame_tick (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vblank,
  input  logic       clr,
  input  logic [7:0] len,
  output logic       tick,
  output logic       done
);
  logic       vblank_q;
  logic [7:0] cnt;
  assign tick = vblank & ~vblank_q;
  assign done = tick && (cnt == len - 8'd1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vblank_q <= 1'b0;
      cnt      <= 8'd0;
    end else begin
      vblank_q <= vblank;
      cnt      <= clr ? 8'd0 : tick ? cnt + 8'd1 : cnt;
    end
endmodule

// File: rtl/coin_start_seq.sv
// coin_start_seq: turns start-button presses into timed coin pulse(s), gap and start pulse, in frames
module coin_start_seq import coin_start_pkg::*; #(
  parameter int COIN_FRAMES  = 4,
  parameter int GAP_FRAMES   = 8,
  parameter int START_FRAMES = 4,
  parameter int P2_COINS     = 2
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic I_VBLANK,
  input  logic I_START1,
  input  logic I_START2,
  output logic O_COIN,
  output logic O_START1,
  output logic O_START2,
  output logic O_BUSY
);
  localparam logic [7:0] COIN_N  = max1(COIN_FRAMES);
  localparam logic [7:0] GAP_N   = max1(GAP_FRAMES);
  localparam logic [7:0] START_N = max1(START_FRAMES);
  localparam logic [7:0] P2_N    = max1(P2_COINS);
  state_t     state, nxt;
  logic       sel, s1_q, s2_q, e1, e2, tick, done, clr, btn;
  logic [7:0] coins_left, len;
  assign e1  = I_START1 & ~s1_q;
  assign e2  = I_START2 & ~s2_q;
  assign btn = sel ? I_START2 : I_START1;
  assign clr = nxt != state;
  always_comb begin
    len = (state == COIN) ? COIN_N : (state == GAP) ? GAP_N : START_N;
    nxt = (state == IDLE && (e1 || e2))       ? COIN :
          (state == COIN && done)             ? GAP :
          (state == GAP && done)              ? ((coins_left != 8'd0) ? COIN : START) :
          (state == START && done)            ? RELEASE :
          (state == RELEASE && tick && !btn)  ? IDLE : state;
  end
  frame_tick u_tick (
    .clk    (CLK),
    .rst_n  (RESET_N),
    .vblank (I_VBLANK),
    .clr    (clr),
    .len    (len),
    .tick   (tick),
    .done   (done)
  );
  // outputs decode the next state so they switch together with the state register
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      state      <= IDLE;
      sel        <= 1'b0;
      coins_left <= 8'd0;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      O_COIN     <= 1'b0;
      O_START1   <= 1'b0;
      O_START2   <= 1'b0;
      O_BUSY     <= 1'b0;
    end else begin
      s1_q  <= I_START1;
      s2_q  <= I_START2;
      state <= nxt;
      if (state == IDLE && nxt == COIN) begin
        sel        <= e2;
        coins_left <= e2 ? P2_N : 8'd1;
      end else if (state == COIN && nxt == GAP)
        coins_left <= coins_left - 8'd1;
      O_COIN   <= nxt == COIN;
      O_START1 <= nxt == START && !sel;
      O_START2 <= nxt == START && sel;
      O_BUSY   <= nxt != IDLE;
    end
endmodule
